// File: rtl/shift_issue_ctrl_if.sv
// Request/response handshake plus the operand/result bus to the external Shifter.
// The controller uses the slave modport; the requester/consumer and Shifter side uses master.
interface shift_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic [31:0] sh_a;
    logic [31:0] sh_b;
    logic        sh_ctl0;
    logic        sh_ctl1;
    logic [31:0] sh_out;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_ovf;
    logic        out_err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, sh_out, out_ready,
        output in_ready, sh_a, sh_b, sh_ctl0, sh_ctl1,
        output out_valid, out_result, out_zero, out_neg, out_ovf, out_err
    );

    modport master (
        output in_valid, in_op, in_a, in_b, sh_out, out_ready,
        input  in_ready, sh_a, sh_b, sh_ctl0, sh_ctl1,
        input  out_valid, out_result, out_zero, out_neg, out_ovf, out_err
    );
endinterface

// File: rtl/shift_issue_ctrl.sv
// Issue/response sequencer around a combinational 32-bit shifter: registers operands,
// waits a settle window, then captures the saturated result with its flags.
module shift_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_issue_ctrl_if.slave bus
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("shift_issue_ctrl: SETTLE_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        ovf_q;
    logic [31:0] sh_a_q;
    logic [31:0] sh_b_q;
    logic        ctl0_q;
    logic        ctl1_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        neg_q;
    logic        ovf_out_q;
    logic        err_q;

    logic        in_ready_c;
    logic        accept;
    logic [31:0] capture;

    // In RESP the next request may be taken on the same edge the current result retires.
    always_comb begin
        in_ready_c = rst_n && ((state == IDLE) || ((state == RESP) && bus.out_ready));
        accept     = bus.in_valid && in_ready_c;
        capture    = bus.sh_out;
        if (ovf_q) begin
            capture = ctl0_q ? {32{sh_a_q[31]}} : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'h0;
            ovf_q     <= 1'b0;
            sh_a_q    <= 32'h0;
            sh_b_q    <= 32'h0;
            ctl0_q    <= 1'b0;
            ctl1_q    <= 1'b0;
            result_q  <= 32'h0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt != 4'h0) begin
                        cnt <= cnt - 4'h1;
                    end else begin
                        result_q  <= capture;
                        zero_q    <= (capture == 32'h0);
                        neg_q     <= capture[31];
                        ovf_out_q <= ovf_q;
                        err_q     <= 1'b0;
                        state     <= RESP;
                    end
                end
                IDLE, RESP: begin
                    if (accept) begin
                        // A reserved op never touches the shifter registers.
                        if (bus.in_op == OP_RSV) begin
                            result_q  <= 32'h0;
                            zero_q    <= 1'b0;
                            neg_q     <= 1'b0;
                            ovf_out_q <= 1'b0;
                            err_q     <= 1'b1;
                            state     <= RESP;
                        end else begin
                            sh_a_q <= bus.in_a;
                            sh_b_q <= {27'b0, bus.in_b[4:0]};
                            ctl1_q <= (bus.in_op != OP_SLL);
                            ctl0_q <= (bus.in_op == OP_SRA);
                            ovf_q  <= |bus.in_b[31:5];
                            cnt    <= CNT_INIT;
                            state  <= SETTLE;
                        end
                    end else if ((state == IDLE) || bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.sh_a       = sh_a_q;
    assign bus.sh_b       = sh_b_q;
    assign bus.sh_ctl0    = ctl0_q;
    assign bus.sh_ctl1    = ctl1_q;
    assign bus.out_valid  = (state == RESP);
    assign bus.out_result = result_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_neg    = neg_q;
    assign bus.out_ovf    = ovf_out_q;
    assign bus.out_err    = err_q;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Bench for shift_issue_ctrl: a SETTLE_CYCLES=1 instance driven from a vector table with a
// response scoreboard, and a SETTLE_CYCLES=4 instance used for the mid-operation reset case.
module tb_shift_issue_ctrl;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic        ovf;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n1;
    logic rst_n4;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    vec_t exp_q[$];
    vec_t tbl[12];
    vec_t va;
    vec_t vb;

    logic [31:0] last_a;
    logic        last_ctl0;
    logic        last_ctl1;

    shift_issue_ctrl_if bus1();
    shift_issue_ctrl_if bus4();

    shift_issue_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(bus1));
    shift_issue_ctrl #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n4), .bus(bus4));

    function automatic logic [31:0] shifter(input logic [31:0] a, input logic [31:0] b,
                                            input logic ctl0, input logic ctl1);
        logic [31:0] r;
        if (!ctl1)     r = a << b;
        else if (ctl0) r = $signed(a) >>> b;
        else           r = a >> b;
        return r;
    endfunction

    assign bus1.sh_out = shifter(bus1.sh_a, bus1.sh_b, bus1.sh_ctl0, bus1.sh_ctl1);
    assign bus4.sh_out = shifter(bus4.sh_a, bus4.sh_b, bus4.sh_ctl0, bus4.sh_ctl1);

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one request on the SETTLE_CYCLES=1 instance and returns just after its accept edge.
    task automatic applyStimulus(input vec_t v);
        int  tries;
        bit  got;
        tries = 0;
        got   = 1'b0;
        bus1.in_op    = v.op;
        bus1.in_a     = v.a;
        bus1.in_b     = v.b;
        bus1.in_valid = 1'b1;
        while (!got && tries < 20) begin
            @(negedge clk);
            if (bus1.in_ready) begin
                got = 1'b1;
                exp_q.push_back(v);
            end
            @(posedge clk);
            #1;
            tries++;
        end
        bus1.in_valid = 1'b0;
        checkOutput("accept_handshake", 32'(got), 32'd1);
    endtask

    task automatic waitResponse(input int exp_lat, input string name);
        int lat;
        lat = 1;
        while (!bus1.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput(name, lat, exp_lat);
    endtask

    initial begin
        tbl[0]  = '{2'b00, 32'h0000_0001, 32'd4,          32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, 32'h8000_0000, 32'd31,         32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'b01, 32'h8000_0000, 32'd32,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{2'b10, 32'h8000_0001, 32'd40,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0100,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 32'h0000_1234, 32'd0,          32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{2'b00, 32'hA5A5_A5A5, 32'd0,          32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{2'b10, 32'h7FFF_FFF0, 32'd4,          32'h07FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'b01, 32'hF000_0000, 32'h2000_0004,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{2'b10, 32'h4000_0000, 32'd33,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{2'b00, 32'h1234_5678, 32'd8,          32'h3456_7800, 1'b0, 1'b0, 1'b0, 1'b0};

        bus1.in_valid = 1'b0; bus1.in_op = 2'b00; bus1.in_a = 32'h0; bus1.in_b = 32'h0;
        bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_op = 2'b00; bus4.in_a = 32'h0; bus4.in_b = 32'h0;
        bus4.out_ready = 1'b1;
        rst_n1 = 1'b0;
        rst_n4 = 1'b0;

        // Scoreboard side: every response taken by the consumer is checked against the oldest request.
        fork
            forever begin
                vec_t e;
                @(negedge clk);
                if (rst_n1 && bus1.out_valid && bus1.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_response", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_result", bus1.out_result, e.result);
                        checkOutput("out_zero",   32'(bus1.out_zero), 32'(e.zero));
                        checkOutput("out_neg",    32'(bus1.out_neg),  32'(e.neg));
                        checkOutput("out_ovf",    32'(bus1.out_ovf),  32'(e.ovf));
                        checkOutput("out_err",    32'(bus1.out_err),  32'(e.err));
                    end
                end
            end
        join_none

        #2;
        checkOutput("rst_in_ready",  32'(bus1.in_ready),  32'd0);
        checkOutput("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("rst_result",    bus1.out_result,     32'h0);
        checkOutput("rst_sh_a",      bus1.sh_a,           32'h0);
        checkOutput("rst_sh_ctl",    {30'b0, bus1.sh_ctl1, bus1.sh_ctl0}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n1 = 1'b1;
        rst_n4 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_in_ready", 32'(bus1.in_ready), 32'd1);

        last_a    = 32'h0;
        last_ctl0 = 1'b0;
        last_ctl1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i]);
            if (tbl[i].op != 2'b11) begin
                last_a    = tbl[i].a;
                last_ctl1 = (tbl[i].op != 2'b00);
                last_ctl0 = (tbl[i].op == 2'b10);
                checkOutput("sh_b", bus1.sh_b, {27'b0, tbl[i].b[4:0]});
            end
            checkOutput("sh_a", bus1.sh_a, last_a);
            checkOutput("sh_ctl", {30'b0, bus1.sh_ctl1, bus1.sh_ctl0}, {30'b0, last_ctl1, last_ctl0});
            waitResponse(tbl[i].err ? 1 : 2, "latency");
        end
        @(posedge clk);
        #1;

        // Backpressure: result must hold and the pending request must wait for out_ready.
        bus1.out_ready = 1'b0;
        va = '{2'b00, 32'h0000_0003, 32'd1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0};
        vb = '{2'b01, 32'h0000_0100, 32'd4, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(va);
        waitResponse(2, "bp_latency");
        bus1.in_op    = vb.op;
        bus1.in_a     = vb.a;
        bus1.in_b     = vb.b;
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready",  32'(bus1.in_ready),  32'd0);
            checkOutput("bp_out_valid", 32'(bus1.out_valid), 32'd1);
            checkOutput("bp_result",    bus1.out_result,     32'h0000_0006);
            checkOutput("bp_sh_a",      bus1.sh_a,           32'h0000_0003);
            @(posedge clk);
            #1;
        end
        bus1.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_same_edge_ready", 32'(bus1.in_ready), 32'd1);
        exp_q.push_back(vb);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        checkOutput("bp_second_sh_a",   bus1.sh_a,             32'h0000_0100);
        checkOutput("bp_retired_valid", 32'(bus1.out_valid),   32'd0);
        waitResponse(2, "bp_second_latency");
        @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        // Mid-SETTLE reset on the 4-cycle instance aborts the operation.
        begin
            bit saw_valid;
            int lat;
            bus4.in_op    = 2'b00;
            bus4.in_a     = 32'h0000_0001;
            bus4.in_b     = 32'd4;
            bus4.in_valid = 1'b1;
            @(negedge clk);
            checkOutput("t6_accept_ready", 32'(bus4.in_ready), 32'd1);
            @(posedge clk);
            #1;
            bus4.in_valid = 1'b0;
            @(posedge clk);
            #1;
            rst_n4 = 1'b0;
            #1;
            checkOutput("t6_rst_in_ready",  32'(bus4.in_ready),  32'd0);
            checkOutput("t6_rst_out_valid", 32'(bus4.out_valid), 32'd0);
            checkOutput("t6_rst_sh_a",      bus4.sh_a,           32'h0);
            @(negedge clk);
            @(negedge clk);
            rst_n4 = 1'b1;
            saw_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                saw_valid = saw_valid | bus4.out_valid;
            end
            checkOutput("t6_no_out_valid", 32'(saw_valid), 32'd0);
            checkOutput("t6_in_ready",     32'(bus4.in_ready), 32'd1);

            bus4.in_op    = 2'b00;
            bus4.in_a     = 32'h0000_000F;
            bus4.in_b     = 32'd4;
            bus4.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus4.in_valid = 1'b0;
            lat = 1;
            while (!bus4.out_valid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checkOutput("t6_latency", lat, 32'd5);
            checkOutput("t6_result",  bus4.out_result, 32'h0000_00F0);
            checkOutput("t6_flags",   {28'b0, bus4.out_zero, bus4.out_neg, bus4.out_ovf, bus4.out_err}, 32'h0);
            @(posedge clk);
            #1;
            checkOutput("t6_retired", 32'(bus4.out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
